cv32e41s_rvfi_trace_tx: RTL

Synthesizable RVFI trace transmitter. It captures each retired instruction from the core's RVFI port, buffers the record in a small FIFO, and serializes it as a byte-wide packet stream over a valid/ready link. An off-chip or testbench-side receiver uses that stream to rebuild the instruction trace log. It sits beside the core's RVFI output and is the producer end of the trace log path.

---
 rtl/cv32e41s_rvfi_pkg.sv | 66 ++++++
 rtl/cv32e41s_rvfi_trace_tx_if.sv | 9 +
 rtl/cv32e41s_rvfi_trace_fifo.sv | 62 ++++++
 rtl/cv32e41s_rvfi_trace_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cv32e41s_rvfi_pkg.sv
// Shared types and helpers for the RVFI trace transmitter.
// Memory fields are present only when CV32E41S_RVFI_TRACE_TX_MEM_EN is defined.
package cv32e41s_rvfi_pkg;

    localparam logic [7:0]  RVFI_TRACE_SYNC     = 8'hA5;
    localparam int unsigned RVFI_TRACE_LEN_BASE = 10;
    localparam int unsigned RVFI_TRACE_LEN_MEM  = 19;
    localparam int unsigned RVFI_TRACE_IDX_W    = 5;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } rvfi_trace_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [1:0]  seq;
        logic        has_mem;
`ifdef CV32E41S_RVFI_TRACE_TX_MEM_EN
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
`endif
    } rvfi_trace_rec_t;

    function automatic logic [RVFI_TRACE_IDX_W-1:0] rvfi_trace_len(input rvfi_trace_rec_t rec);
        return rec.has_mem ? RVFI_TRACE_IDX_W'(RVFI_TRACE_LEN_MEM)
                           : RVFI_TRACE_IDX_W'(RVFI_TRACE_LEN_BASE);
    endfunction

    // Packet byte at position idx; multi-byte fields are little-endian.
    function automatic logic [7:0] rvfi_trace_byte(input rvfi_trace_rec_t rec,
                                                   input logic [RVFI_TRACE_IDX_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            5'd0:  b = RVFI_TRACE_SYNC;
            5'd1:  b = {rec.has_mem, rec.seq, rec.rd_addr};
            5'd2:  b = rec.pc[7:0];
            5'd3:  b = rec.pc[15:8];
            5'd4:  b = rec.pc[23:16];
            5'd5:  b = rec.pc[31:24];
            5'd6:  b = rec.rd_wdata[7:0];
            5'd7:  b = rec.rd_wdata[15:8];
            5'd8:  b = rec.rd_wdata[23:16];
            5'd9:  b = rec.rd_wdata[31:24];
`ifdef CV32E41S_RVFI_TRACE_TX_MEM_EN
            5'd10: b = {rec.rmask, rec.wmask};
            5'd11: b = rec.mem_addr[7:0];
            5'd12: b = rec.mem_addr[15:8];
            5'd13: b = rec.mem_addr[23:16];
            5'd14: b = rec.mem_addr[31:24];
            5'd15: b = rec.mem_data[7:0];
            5'd16: b = rec.mem_data[15:8];
            5'd17: b = rec.mem_data[23:16];
            5'd18: b = rec.mem_data[31:24];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cv32e41s_rvfi_trace_tx_if.sv
// Byte-wide valid/ready trace link between the transmitter and its receiver.
interface cv32e41s_rvfi_trace_tx_if;
    logic       tx_valid_o;
    logic [7:0] tx_data_o;
    logic       tx_ready_i;

    modport master (output tx_valid_o, output tx_data_o, input tx_ready_i);
    modport slave  (input tx_valid_o, input tx_data_o, output tx_ready_i);
endinterface

// File: rtl/cv32e41s_rvfi_trace_fifo.sv
// Record FIFO for the trace transmitter; DEPTH must be a power of two.
// Pushes when full and pops when empty are ignored.
module cv32e41s_rvfi_trace_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   i_push,
    input  T                       i_data,
    input  logic                   i_pop,
    output T                       o_data_c,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full_c,
    output logic                   o_empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push    = i_push && !o_full_c;
    assign w_pop     = i_pop && !o_empty_c;
    assign o_full_c  = (r_count == CNT_W'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_data_c  = r_mem[r_rptr];
    assign o_count   = r_count;

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cv32e41s_rvfi_trace_tx.sv
// RVFI trace transmitter: captures retired instructions, queues them and sends
// byte packets over a valid/ready link. Memory fields need CV32E41S_RVFI_TRACE_TX_MEM_EN.
module cv32e41s_rvfi_trace_tx
    import cv32e41s_rvfi_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NMEM  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rvfi_valid,
    input  logic [31:0]           rvfi_pc_rdata,
    input  logic [4:0]            rvfi_rd_addr,
    input  logic [31:0]           rvfi_rd_wdata,
    input  logic [32*NMEM-1:0]    rvfi_mem_addr,
    input  logic [4*NMEM-1:0]     rvfi_mem_rmask,
    input  logic [4*NMEM-1:0]     rvfi_mem_wmask,
    input  logic [32*NMEM-1:0]    rvfi_mem_rdata,
    input  logic [32*NMEM-1:0]    rvfi_mem_wdata,
    cv32e41s_rvfi_trace_tx_if.master tx,
    output logic [7:0]            drop_cnt_o,
    output logic                  overflow_o
);

    localparam int unsigned IDX_W = RVFI_TRACE_IDX_W;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    rvfi_trace_state_e r_state;
    rvfi_trace_state_e w_state_nxt;
    rvfi_trace_rec_t   w_rec;
    rvfi_trace_rec_t   w_head;
    rvfi_trace_rec_t   r_pkt;
    logic [IDX_W-1:0]  r_idx;
    logic [1:0]        r_seq;
    logic [7:0]        r_drop_cnt;
    logic              r_overflow;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic              w_adv;
    logic              w_done;
    logic              w_last;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_unused_count;

    // Record formed from lane 0 of the retire port.
    always_comb begin
        w_rec          = '0;
        w_rec.pc       = rvfi_pc_rdata;
        w_rec.rd_addr  = rvfi_rd_addr;
        w_rec.rd_wdata = rvfi_rd_wdata;
        w_rec.seq      = r_seq;
`ifdef CV32E41S_RVFI_TRACE_TX_MEM_EN
        w_rec.rmask    = rvfi_mem_rmask[3:0];
        w_rec.wmask    = rvfi_mem_wmask[3:0];
        w_rec.mem_addr = rvfi_mem_addr[31:0];
        w_rec.mem_data = (|rvfi_mem_rmask[3:0]) ? rvfi_mem_rdata[31:0] : rvfi_mem_wdata[31:0];
        w_rec.has_mem  = |(rvfi_mem_rmask[3:0] | rvfi_mem_wmask[3:0]);
`else
        w_rec.has_mem  = 1'b0;
`endif
    end

`ifndef CV32E41S_RVFI_TRACE_TX_MEM_EN
    logic w_unused_mem;
    assign w_unused_mem = ^{rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
                            rvfi_mem_rdata, rvfi_mem_wdata};
`else
    if (NMEM > 1) begin : g_unused_lanes
        logic w_unused_lanes;
        assign w_unused_lanes = ^{rvfi_mem_addr[32*NMEM-1:32], rvfi_mem_rmask[4*NMEM-1:4],
                                  rvfi_mem_wmask[4*NMEM-1:4], rvfi_mem_rdata[32*NMEM-1:32],
                                  rvfi_mem_wdata[32*NMEM-1:32]};
    end
`endif

    // A full FIFO drops the record even if it is popped this cycle.
    assign w_push = rvfi_valid && !w_full;
    assign w_drop = rvfi_valid && w_full;

    cv32e41s_rvfi_trace_fifo #(
        .T     (rvfi_trace_rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_push    (w_push),
        .i_data    (w_rec),
        .i_pop     (w_pop),
        .o_data_c  (w_head),
        .o_count   (w_unused_count),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_seq      <= 2'd0;
            r_drop_cnt <= 8'd0;
            r_overflow <= 1'b0;
        end else begin
            if (rvfi_valid) begin
                r_seq <= r_seq + 2'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    assign w_last = (r_idx == (rvfi_trace_len(r_pkt) - IDX_W'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Last-byte handshake chains straight into the next packet when one is queued.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_adv       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx.tx_ready_i) begin
                    if (!w_last) begin
                        w_adv = 1'b1;
                    end else if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_done      = 1'b1;
                        w_state_nxt = TX_IDLE;
                    end
                end
            end
            default: w_state_nxt = TX_IDLE;
        endcase
    end

    // The next link byte is precomputed so both link outputs come straight from flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pkt      <= '0;
            r_idx      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_valid <= (w_state_nxt == TX_SEND);
            if (w_pop) begin
                r_pkt     <= w_head;
                r_idx     <= '0;
                r_tx_data <= RVFI_TRACE_SYNC;
            end else if (w_adv) begin
                r_idx     <= r_idx + IDX_W'(1);
                r_tx_data <= rvfi_trace_byte(r_pkt, r_idx + IDX_W'(1));
            end else if (w_done) begin
                r_tx_data <= 8'h00;
            end
        end
    end

    assign tx.tx_valid_o = r_tx_valid;
    assign tx.tx_data_o  = r_tx_data;
    assign drop_cnt_o    = r_drop_cnt;
    assign overflow_o    = r_overflow;

endmodule
